seed_role_reader: RTL and testbench
===================================

# seed_role_reader

Reads one role-assignment word from the seed ROM and unpacks it into the per-game role registers: wolf index, doctor index, the latched 10-bit role vector, and a consistency flag. It sits between the game controller and the seed ROM. A free-running counter supplies the pseudo-random seed address, captured on `start`. The ROM is read with its one-cycle registered latency, then the five 2-bit player fields are scanned serially, one per cycle.

## Interface
- `NUM_SEEDS`, default 20: number of valid ROM entries; counter wraps at `NUM_SEEDS-1`.
- `clock`  in  1: single clock, all logic on rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `start`  in  1: request a new role assignment; sampled only in IDLE.
- `rom_address`  out  5: address to seed ROM (registered).
- `rom_data`  in  10: ROM word, valid the cycle after the ROM samples `rom_address`.
- `busy`  out  1: high from the edge after `start` is accepted until return to IDLE.
- `done`  out  1: one-cycle pulse when results are final.
- `error`  out  1: word failed validation; held until next accepted `start`.
- `seed_index`  out  5: counter value captured at accepted `start`.
- `roles`  out  10: latched ROM word; player p occupies bits [9-2p:8-2p].
- `wolf_idx`  out  3: player holding wolf (01); 7 = none.
- `doctor_idx`  out  3: player holding doctor (10); 7 = none.

## Operation
- Field encoding: 00 villager, 01 wolf, 10 doctor, 11 illegal.
- Seed counter: resets to 0, increments every edge in every state, wraps `NUM_SEEDS-1` → 0.
- FSM states:
  - IDLE: `start`=1 → REQ. `seed_index` and `rom_address` load the counter; `error` clears. Otherwise stay.
  - REQ: ROM samples the address. Go to WAIT.
  - WAIT: latch `rom_data` into `roles`. Clear the scan index, wolf/doctor counts and illegal flag. Go to SCAN.
  - SCAN: examine field p (p=0..4, one per edge).
    - On wolf, increment the wolf count. If it was 0, set `wolf_idx`=p.
    - Doctor is handled the same way for `doctor_idx`.
    - On 11, set the illegal flag.
    - After p=4 → DONE. On that edge, `error` = (wolf count≠1) | (doctor count≠1) | illegal, using final counts.
  - DONE: `done`=1 for this one cycle. Go to IDLE.
- Multiple wolves or doctors: keep the lowest index and set `error`.
- No wolf or no doctor: that index stays 7 and `error`=1.
- `wolf_idx`/`doctor_idx` are set to 7 when entering SCAN. Their final values are stable from DONE until the next accepted `start`.
- `start` outside IDLE is ignored (no queuing). `start` held high re-triggers on the first IDLE cycle after DONE.
- Counts are 3 bits wide and cannot overflow with 5 fields.

## Timing
- Reset values: `busy`=0, `done`=0, `error`=0, `rom_address`=0, `seed_index`=0, `roles`=0, `wolf_idx`=7, `doctor_idx`=7, FSM=IDLE, counter=0.
- Edge E0: `start` sampled in IDLE.
- E1: REQ. ROM registers the address.
- E2: `roles` latched.
- E3..E7: fields 0..4 scanned.
- DONE cycle follows E7: `done`=1, 8 cycles after `start` was sampled.
- E8: IDLE, `busy`=0.
- `busy` is high from after E0 through the DONE cycle.
- `rom_address` is held constant from E0 until the next accepted `start`.
- Reset asserted mid-operation: all outputs return to reset values on that edge and no `done` pulse is produced. `start` is ignored while `reset_n`=0.
- Counter wrap coinciding with `start`: the captured value is the pre-increment value.

## Test plan
- Reset, then `start` when counter=5 with the ROM model:
  - `seed_index`=5, `rom_address`=5, `roles`=10'b00_01_10_00_00.
  - `wolf_idx`=1, `doctor_idx`=2, `error`=0.
  - `done` pulses exactly 8 cycles after `start`.
- `start` when counter=19, then again when counter=0 (wrap):
  - Seed 19 gives wolf 4, doctor 3.
  - Seed 0 gives wolf 0, doctor 1.
  - Both have `error`=0.
- Injected `rom_data`=10'b01_01_00_00_00 → `wolf_idx`=0, `doctor_idx`=7, `error`=1.
- Injected `rom_data`=10'b11_10_00_01_00 → `wolf_idx`=3, `doctor_idx`=1, `error`=1 (illegal field).
- `start` pulsed at E2 and E5 of a running request → ignored: a single `done`, and `seed_index` unchanged.
- `reset_n` low at E4 → next cycle all outputs at reset values, no `done`. A following `start` completes normally.

Source files
------------

// File: rtl/seed_role_reader.sv
// Seed ROM role reader: captures a pseudo-random seed address, reads one word,
// then scans its five 2-bit player fields to locate the wolf and the doctor.
module seed_role_reader #(
    parameter int NUM_SEEDS = 20
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    output logic [4:0] rom_address,
    input  logic [9:0] rom_data,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [4:0] seed_index,
    output logic [9:0] roles,
    output logic [2:0] wolf_idx,
    output logic [2:0] doctor_idx
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        SCAN,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] counter;
    logic [2:0] scan_idx;
    logic [2:0] wolf_cnt;
    logic [2:0] doctor_cnt;
    logic [2:0] wolf_nxt;
    logic [2:0] doctor_nxt;
    logic       illegal;
    logic       illegal_nxt;
    logic [1:0] field;
    logic       last;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            counter <= '0;
        end else if (counter == 5'(NUM_SEEDS - 1)) begin
            counter <= '0;
        end else begin
            counter <= counter + 5'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     state_nxt = WAIT;
            WAIT:    state_nxt = SCAN;
            SCAN:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Player p sits in bits [9-2p:8-2p], so player 0 is the top pair.
    always_comb begin
        case (scan_idx)
            3'd0:    field = roles[9:8];
            3'd1:    field = roles[7:6];
            3'd2:    field = roles[5:4];
            3'd3:    field = roles[3:2];
            default: field = roles[1:0];
        endcase
    end

    assign last        = (scan_idx == 3'd4);
    assign wolf_nxt    = wolf_cnt + {2'b00, field == 2'b01};
    assign doctor_nxt  = doctor_cnt + {2'b00, field == 2'b10};
    assign illegal_nxt = illegal | (field == 2'b11);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rom_address <= '0;
            seed_index  <= '0;
            error       <= 1'b0;
            roles       <= '0;
            wolf_idx    <= 3'd7;
            doctor_idx  <= 3'd7;
            scan_idx    <= '0;
            wolf_cnt    <= '0;
            doctor_cnt  <= '0;
            illegal     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        seed_index  <= counter;
                        rom_address <= counter;
                        error       <= 1'b0;
                    end
                end
                WAIT: begin
                    roles      <= rom_data;
                    scan_idx   <= '0;
                    wolf_cnt   <= '0;
                    doctor_cnt <= '0;
                    illegal    <= 1'b0;
                    wolf_idx   <= 3'd7;
                    doctor_idx <= 3'd7;
                end
                SCAN: begin
                    scan_idx   <= scan_idx + 3'd1;
                    wolf_cnt   <= wolf_nxt;
                    doctor_cnt <= doctor_nxt;
                    illegal    <= illegal_nxt;
                    // Only the first occurrence claims the index.
                    if (field == 2'b01 && wolf_cnt == 3'd0) begin
                        wolf_idx <= scan_idx;
                    end
                    if (field == 2'b10 && doctor_cnt == 3'd0) begin
                        doctor_idx <= scan_idx;
                    end
                    if (last) begin
                        error <= (wolf_nxt != 3'd1) |
                                 (doctor_nxt != 3'd1) |
                                 illegal_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seed_role_reader.sv
// Bench for seed_role_reader: directed table, randomized words against a
// field-scanning reference model, start-while-busy and mid-run reset.
module tb_seed_role_reader;

    localparam int NS = 20;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [4:0] rom_address;
    logic [9:0] rom_data;
    logic       busy;
    logic       done;
    logic       error;
    logic [4:0] seed_index;
    logic [9:0] roles;
    logic [2:0] wolf_idx;
    logic [2:0] doctor_idx;

    logic [9:0] rom [NS];
    logic [9:0] rom_q;
    logic       inject;
    logic [9:0] inj_data;
    int         mcnt;
    int         total = 0;
    int         bad = 0;

    seed_role_reader #(.NUM_SEEDS(NS)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .rom_address(rom_address),
        .rom_data   (rom_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .seed_index (seed_index),
        .roles      (roles),
        .wolf_idx   (wolf_idx),
        .doctor_idx (doctor_idx)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (int'(rom_address) < NS) rom_q <= rom[rom_address];
        else rom_q <= '0;
    end

    assign rom_data = inject ? inj_data : rom_q;

    always @(posedge clock) begin
        if (!reset_n) mcnt <= 0;
        else mcnt <= (mcnt == NS - 1) ? 0 : mcnt + 1;
    end

    typedef struct {
        logic       inj;
        logic [9:0] data;
        int         cnt;
        logic [2:0] ew;
        logic [2:0] ed;
        logic       ee;
    } vec_t;

    vec_t vt [6];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Returns {wolf, doctor, error} from the field rules.
    function automatic logic [6:0] model(input logic [9:0] w);
        int nw = 0;
        int nd = 0;
        logic ill = 1'b0;
        logic [2:0] wi = 3'd7;
        logic [2:0] di = 3'd7;
        for (int p = 0; p < 5; p++) begin
            logic [1:0] f;
            f = w[9 - 2 * p -: 2];
            if (f == 2'b01) begin
                if (nw == 0) wi = 3'(p);
                nw++;
            end else if (f == 2'b10) begin
                if (nd == 0) di = 3'(p);
                nd++;
            end else if (f == 2'b11) begin
                ill = 1'b1;
            end
        end
        return {wi, di, (nw != 1) || (nd != 1) || ill};
    endfunction

    task automatic run_txn(input logic inj, input logic [9:0] idata,
                           input int want, input logic use_exp,
                           input logic [2:0] ew, input logic [2:0] ed,
                           input logic ee, input logic pulse_mid);
        int n;
        int edges;
        int lat;
        logic [9:0] word;
        logic [6:0] m;
        inject = inj;
        inj_data = idata;
        n = 0;
        while (mcnt != want && n < 50) begin
            step();
            n++;
        end
        chk("cnt_wait", mcnt, want);
        word = inj ? idata : rom[want];
        m = model(word);
        start = 1'b1;
        step();
        start = 1'b0;
        edges = 1;
        lat = 0;
        chk("busy_e0", int'(busy), 1);
        while (edges < 20 && lat == 0) begin
            start = pulse_mid && (edges == 2 || edges == 5);
            step();
            edges++;
            if (done) lat = edges;
        end
        start = 1'b0;
        chk("done_lat", lat, 8);
        chk("seed_index", int'(seed_index), want);
        chk("rom_address", int'(rom_address), want);
        chk("roles", int'(roles), int'(word));
        chk("wolf_model", int'(wolf_idx), int'(m[6:4]));
        chk("doctor_model", int'(doctor_idx), int'(m[3:1]));
        chk("error_model", int'(error), int'(m[0]));
        if (use_exp) begin
            chk("wolf_exp", int'(wolf_idx), int'(ew));
            chk("doctor_exp", int'(doctor_idx), int'(ed));
            chk("error_exp", int'(error), int'(ee));
        end
        step();
        chk("done_pulse", int'(done), 0);
        chk("busy_idle", int'(busy), 0);
        if (pulse_mid) begin
            n = 0;
            for (int i = 0; i < 10; i++) begin
                step();
                if (done || busy) n++;
            end
            chk("no_retrigger", n, 0);
            chk("seed_kept", int'(seed_index), want);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_error"}, int'(error), 0);
        chk({tag, "_addr"}, int'(rom_address), 0);
        chk({tag, "_seed"}, int'(seed_index), 0);
        chk({tag, "_roles"}, int'(roles), 0);
        chk({tag, "_wolf"}, int'(wolf_idx), 7);
        chk({tag, "_doctor"}, int'(doctor_idx), 7);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        start = 1'b0;
        inject = 1'b0;
        inj_data = '0;
        for (int i = 0; i < NS; i++) rom[i] = 10'($urandom);
        rom[0]  = 10'b01_10_00_00_00;
        rom[5]  = 10'b00_01_10_00_00;
        rom[19] = 10'b00_00_00_10_01;

        vt[0] = '{1'b0, 10'd0, 5, 3'd1, 3'd2, 1'b0};
        vt[1] = '{1'b0, 10'd0, 19, 3'd4, 3'd3, 1'b0};
        vt[2] = '{1'b0, 10'd0, 0, 3'd0, 3'd1, 1'b0};
        vt[3] = '{1'b1, 10'b01_01_00_00_00, 3, 3'd0, 3'd7, 1'b1};
        vt[4] = '{1'b1, 10'b11_10_00_01_00, 11, 3'd3, 3'd1, 1'b1};
        vt[5] = '{1'b1, 10'b00_00_00_00_00, 8, 3'd7, 3'd7, 1'b1};

        step();
        step();
        chk_reset_vals("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_txn(vt[i].inj, vt[i].data, vt[i].cnt, 1'b1,
                    vt[i].ew, vt[i].ed, vt[i].ee, 1'b0);
        end

        run_txn(1'b0, 10'd0, 5, 1'b1, 3'd1, 3'd2, 1'b0, 1'b1);

        for (int i = 0; i < 25; i++) begin
            run_txn(1'($urandom_range(0, 1)), 10'($urandom),
                    int'($urandom_range(0, NS - 1)), 1'b0,
                    3'd0, 3'd0, 1'b0, 1'b0);
        end

        inject = 1'b0;
        n = 0;
        while (mcnt != 7 && n < 50) begin
            step();
            n++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        reset_n = 1'b0;
        start = 1'b1;
        step();
        chk_reset_vals("midreset");
        step();
        start = 1'b0;
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) n++;
        end
        chk("no_done_after_reset", n, 0);
        run_txn(1'b0, 10'd0, 19, 1'b1, 3'd4, 3'd3, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
